// File: rtl/fir_pkg.sv
// Shared definitions for the folded 7-tap FIR: widths, fixed-point constants
// and the MAC sequencing state encoding.
package fir_pkg;

    localparam int NTAPS      = 7;
    localparam int DW         = 8;
    localparam int AW         = 2 * DW;
    localparam int TAP_W      = 3;
    localparam int PROD_SHIFT = 1;
    localparam int Y_MSB      = 15;
    localparam int Y_LSB      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/fir_mac.sv
// Single shared multiply-accumulate: acc += (a*b) >> 1, wrapping modulo 2^AW.
// y_next is the integer byte of the value acc takes at the coming edge.
module fir_mac
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          Rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y_next
);

    logic [AW-1:0] prod;
    logic [AW-1:0] term;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] acc_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        prod  = AW'(a) * AW'(b);
        term  = prod >> PROD_SHIFT;
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q + term;
        end
    end

    // NOTE: sequential state uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (Rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign y_next = acc_d[Y_MSB:Y_LSB];

endmodule

// File: rtl/fir_fold_ctrl.sv
// Folded 7-tap FIR controller: delay line, shadow/active coefficient banks and
// the IDLE -> MAC -> OUT sequencer driving one shared fir_mac.
module fir_fold_ctrl
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             Rst,
    input  logic             coef_we,
    input  logic [TAP_W-1:0] coef_addr,
    input  logic [DW-1:0]    coef_wdata,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    Xin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    Yout,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [DW-1:0]      x_q      [NTAPS];
    logic [DW-1:0]      x_d      [NTAPS];
    logic [DW-1:0]      shadow_q [NTAPS];
    logic [DW-1:0]      shadow_d [NTAPS];
    logic [DW-1:0]      active_q [NTAPS];
    logic [DW-1:0]      active_d [NTAPS];
    logic [DW-1:0]      yout_q, yout_d;
    logic               out_valid_q, out_valid_d;
    logic [DW-1:0]      y_next;
    logic               accept;
    logic               last_tap;

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_tap = (tap_q == TAP_W'(NTAPS - 1));

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = MAC;
            MAC:     if (last_tap)  state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
    end

    always_comb begin
        x_d         = x_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        tap_d       = tap_q;
        yout_d      = yout_q;
        out_valid_d = out_valid_q;

        // Shadow writes land regardless of state; the active bank only changes on accept.
        if (coef_we && (coef_addr < TAP_W'(NTAPS))) begin
            shadow_d[coef_addr] = coef_wdata;
        end

        if (accept) begin
            x_d[0] = Xin;
            for (int k = 1; k < NTAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
            active_d = shadow_q;
            tap_d    = '0;
        end

        if (state_q == MAC) begin
            tap_d = tap_q + TAP_W'(1);
            if (last_tap) begin
                yout_d      = y_next;
                out_valid_d = 1'b1;
            end
        end

        if ((state_q == OUT) && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: the delay line and coefficient banks are small flop arrays, so they are reset
    // explicitly; a fresh filter must see zero history and zero taps.
    always_ff @(posedge clk) begin
        if (Rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k]      <= '0;
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            tap_q       <= '0;
            yout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            tap_q       <= tap_d;
            yout_q      <= yout_d;
            out_valid_q <= out_valid_d;
        end
    end

    fir_mac u_mac (
        .clk    (clk),
        .Rst    (Rst),
        .clear  (accept),
        .enable (state_q == MAC),
        .a      (active_q[tap_q]),
        .b      (x_q[tap_q]),
        .y_next (y_next)
    );

    assign out_valid = out_valid_q;
    assign Yout      = yout_q;

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Scenario bench for fir_fold_ctrl: expected outputs come from a behavioural
// filter model and are queued at sample accept, then compared at out_valid.
module tb_fir_fold_ctrl;

    logic       clk = 1'b0;
    logic       Rst;
    logic       coef_we;
    logic [2:0] coef_addr;
    logic [7:0] coef_wdata;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Xin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Yout;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int accept_cyc   = 0;

    logic [7:0] m_shadow [7];
    logic [7:0] m_active [7];
    logic [7:0] m_hist   [7];
    logic [7:0] exp_q    [$];
    logic [7:0] last_y;
    logic [7:0] last_exp;

    fir_fold_ctrl dut (
        .clk        (clk),
        .Rst        (Rst),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Xin        (Xin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Yout       (Yout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_y();
        logic [15:0] acc;
        logic [15:0] prod;
        acc = 16'h0000;
        for (int k = 0; k < 7; k++) begin
            prod = 16'(m_active[k]) * 16'(m_hist[k]);
            acc  = acc + (prod >> 1);
        end
        return acc[15:8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 7; k++) begin
            m_shadow[k] = 8'h00;
            m_active[k] = 8'h00;
            m_hist[k]   = 8'h00;
        end
        exp_q.delete();
        last_y = 8'h00;
    endtask

    task automatic do_reset();
        Rst        = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = 3'd0;
        coef_wdata = 8'h00;
        in_valid   = 1'b0;
        Xin        = 8'h00;
        out_ready  = 1'b1;
        step();
        Rst = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input logic [2:0] addr, input logic [7:0] data);
        coef_we    = 1'b1;
        coef_addr  = addr;
        coef_wdata = data;
        step();
        coef_we = 1'b0;
        if (addr < 3'd7) m_shadow[addr] = data;
    endtask

    task automatic accept(input logic [7:0] x);
        int n = 0;
        while (!in_ready && n < 30) begin
            step();
            n++;
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_wait: in_ready=%b required 1 within 30 cycles", in_ready);
        end
        in_valid = 1'b1;
        Xin      = x;
        step();
        in_valid   = 1'b0;
        accept_cyc = cyc;
        m_active   = m_shadow;
        for (int k = 6; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = x;
        exp_q.push_back(model_y());
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL accept_busy: busy=%b in_ready=%b required busy=1 in_ready=0", busy, in_ready);
        end
    endtask

    task automatic receive(input string name, input bit hs);
        int n = 0;
        logic [7:0] e;
        while (out_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_timeout: out_valid=%b required 1 within 30 cycles", name, out_valid);
            return;
        end
        tests_run++;
        if (cyc - accept_cyc != 7 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_latency: latency=%0d in_ready=%b required latency=7 in_ready=0",
                     name, cyc - accept_cyc, in_ready);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        last_exp = e;
        last_y   = Yout;
        tests_run++;
        if (Yout !== e) begin
            tests_failed++;
            $display("FAIL %s_yout: Yout=%h required %h", name, Yout, e);
        end
        if (hs) begin
            out_ready = 1'b1;
            step();
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || Yout !== e) begin
                tests_failed++;
                $display("FAIL %s_handshake: out_valid=%b in_ready=%b Yout=%h required 0 1 %h",
                         name, out_valid, in_ready, Yout, e);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || Yout !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b in_ready=%b out_valid=%b Yout=%h required 0 1 0 00",
                     busy, in_ready, out_valid, Yout);
        end
    endtask

    task automatic test_single_tap();
        do_reset();
        write_coef(3'd0, 8'h40);
        accept(8'h08);
        receive("single_tap", 1'b1);
        tests_run++;
        if (last_y !== 8'h01) begin
            tests_failed++;
            $display("FAIL single_tap_value: Yout=%h required 01", last_y);
        end
    endtask

    task automatic test_impulse_and_step();
        do_reset();
        for (int k = 0; k < 7; k++) write_coef(3'(k), 8'h40);
        accept(8'h08);
        receive("impulse", 1'b1);
        for (int i = 0; i < 8; i++) begin
            accept(8'h00);
            receive("impulse_tail", 1'b1);
        end
        for (int i = 0; i < 7; i++) begin
            accept(8'h08);
            receive("step", 1'b1);
        end
        tests_run++;
        if (last_y !== 8'h07) begin
            tests_failed++;
            $display("FAIL step_final: Yout=%h required 07", last_y);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 7; k++) write_coef(3'(k), 8'hFF);
        for (int i = 0; i < 7; i++) begin
            accept(8'hFF);
            receive("overflow", 1'b1);
        end
        tests_run++;
        if (last_y !== 8'h79) begin
            tests_failed++;
            $display("FAIL overflow_wrap: Yout=%h required 79", last_y);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        write_coef(3'd0, 8'h40);
        write_coef(3'd1, 8'h40);
        out_ready = 1'b0;
        accept(8'h08);
        receive("bp", 1'b0);
        in_valid = 1'b1;
        Xin      = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Yout !== last_exp) begin
                tests_failed++;
                $display("FAIL bp_hold: out_valid=%b in_ready=%b Yout=%h required 1 0 %h",
                         out_valid, in_ready, Yout, last_exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     out_valid, in_ready, busy);
        end
        accept(8'h00);
        receive("bp_next", 1'b1);
    endtask

    task automatic test_shadow_commit();
        do_reset();
        write_coef(3'd0, 8'h40);
        accept(8'h08);
        write_coef(3'd0, 8'h80);
        receive("shadow_cur", 1'b1);
        accept(8'h08);
        receive("shadow_next", 1'b1);
        tests_run++;
        if (last_y !== 8'h02) begin
            tests_failed++;
            $display("FAIL shadow_commit: Yout=%h required 02", last_y);
        end
        write_coef(3'd7, 8'hFF);
        accept(8'h08);
        receive("shadow_addr7", 1'b1);
    endtask

    task automatic test_reset_mid_mac();
        do_reset();
        write_coef(3'd0, 8'h40);
        accept(8'h08);
        step();
        step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        model_clear();
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || Yout !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b in_ready=%b out_valid=%b Yout=%h required 0 1 0 00",
                     busy, in_ready, out_valid, Yout);
        end
        accept(8'h08);
        receive("reset_mid_next", 1'b1);
    endtask

    initial begin
        Rst        = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = 3'd0;
        coef_wdata = 8'h00;
        in_valid   = 1'b0;
        Xin        = 8'h00;
        out_ready  = 1'b1;
        model_clear();
        test_reset();
        test_single_tap();
        test_impulse_and_step();
        test_overflow();
        test_backpressure();
        test_shadow_commit();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
